regfile_scoreboard: RTL and testbench

- Issue-stage interlock controller for the 32x64 register file in the pipelined CPU.
- Tracks outstanding writes per architectural register, stalls an issuing instruction whose sources are still pending, and releases registers on writeback.
- Register 31 is hardwired zero, so it is never tracked and never causes a stall.
- Sits between decode and the register-file read ports; writeback is signalled from the WB stage.

---
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 tb/tb_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle for the register scoreboard.
// Decode drives the issue and writeback fields; the scoreboard returns stall, fire and status.
interface regfile_scoreboard_if #(
  parameter int NUM_REGS = 32
);
  localparam int IDX_W = $clog2(NUM_REGS);

  // Handshake: an instruction presented with issue_valid=1 is accepted in the
  // same cycle exactly when issue_fire=1 (valid & ~stall & ~flush); otherwise
  // decode must hold it and present it again on a later cycle.
  logic                issue_valid;
  logic [IDX_W-1:0]    issue_rs1;
  logic [IDX_W-1:0]    issue_rs2;
  logic                issue_use_rs1;
  logic                issue_use_rs2;
  logic [IDX_W-1:0]    issue_rd;
  logic                issue_wr;
  logic                wb_valid;
  logic [IDX_W-1:0]    wb_rd;
  logic                flush;
  logic                stall;
  logic                issue_fire;
  logic [NUM_REGS-1:0] pending;
  logic                busy;
  logic                err_underflow;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_wr, wb_valid, wb_rd, flush,
    input  stall, issue_fire, pending, busy, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_wr, wb_valid, wb_rd, flush,
    output stall, issue_fire, pending, busy, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Issue-stage interlock: counts outstanding writes per register, stalls readers
// of pending registers, and releases them on writeback (same-cycle bypass).
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 31
) (
  input logic                clk,
  input logic                reset,
  regfile_scoreboard_if.slave sb
);
  localparam int               IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                busy_q;
  logic                err_q;
  logic                err_d;

  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_wb;
  logic             src_haz1;
  logic             src_haz2;
  logic             cap_haz;
  logic             stall;
  logic             issue_fire;
  logic             inc_en;
  logic             dec_en;
  logic             underflow_evt;

  assign cnt_rs1 = cnt_q[sb.issue_rs1];
  assign cnt_rs2 = cnt_q[sb.issue_rs2];
  assign cnt_rd  = cnt_q[sb.issue_rd];
  assign cnt_wb  = cnt_q[sb.wb_rd];

  // The register file writes on the opposite clock phase, so the final
  // outstanding writeback of a source is readable in the same cycle.
  function automatic logic src_haz(input logic             use_rs,
                                   input logic [IDX_W-1:0] rs,
                                   input logic [CNT_W-1:0] cnt_rs);
    logic bypass;
    bypass  = sb.wb_valid && (sb.wb_rd == rs) && (cnt_rs == CNT_ONE);
    src_haz = use_rs && (rs != ZERO_IDX) && (cnt_rs != '0) && !bypass;
  endfunction

  always_comb begin
    src_haz1   = src_haz(sb.issue_use_rs1, sb.issue_rs1, cnt_rs1);
    src_haz2   = src_haz(sb.issue_use_rs2, sb.issue_rs2, cnt_rs2);
    cap_haz    = sb.issue_wr && (sb.issue_rd != ZERO_IDX) && (cnt_rd == CNT_MAX)
                 && !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
    stall      = sb.issue_valid && !sb.flush && (src_haz1 || src_haz2 || cap_haz);
    issue_fire = sb.issue_valid && !stall && !sb.flush;
  end

  // Writebacks and issues in a flush cycle are discarded, so neither counts
  // nor raises an underflow.
  always_comb begin
    inc_en        = issue_fire && sb.issue_wr && (sb.issue_rd != ZERO_IDX);
    dec_en        = !sb.flush && sb.wb_valid && (sb.wb_rd != ZERO_IDX) && (cnt_wb != '0);
    underflow_evt = !sb.flush && sb.wb_valid && (sb.wb_rd != ZERO_IDX) && (cnt_wb == '0);
    err_d         = err_q || underflow_evt;
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sb.flush) begin
        cnt_d[i] = '0;
      end else if (inc_en && (sb.issue_rd == IDX_W'(i)) &&
                   !(dec_en && (sb.wb_rd == IDX_W'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_en && (sb.wb_rd == IDX_W'(i)) &&
                   !(inc_en && (sb.issue_rd == IDX_W'(i)))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      pending_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q <= pending_d;
      busy_q    <= |pending_d;
      err_q     <= err_d;
    end
  end

  assign sb.stall         = stall;
  assign sb.issue_fire    = issue_fire;
  assign sb.pending       = pending_q;
  assign sb.busy          = busy_q;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table with hand-derived
// expectations, then randomized traffic checked against a reference model.
module tb_regfile_scoreboard;
  logic clk;
  logic reset;

  regfile_scoreboard_if sb_if ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        exp_stall;
    logic        exp_fire;
    logic [31:0] exp_pend;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cnt_m[32];
  logic        err_m;

  task automatic add_vec(input logic rst, input logic iv,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr,
                         input logic wbv, input logic [4:0] wbrd, input logic fl,
                         input logic es, input logic ef,
                         input logic [31:0] ep, input logic ee);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.wr = wr; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.exp_stall = es; v.exp_fire = ef; v.exp_pend = ep; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vector %0d): got %h expected %h", name, n_vec, act, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, same-cycle checks, scoreboard for registered outputs
  task automatic run_cycle(input vec_t v);
    logic [33:0] exp_r;
    logic [33:0] act_r;
    @(negedge clk);
    reset                = v.rst;
    sb_if.issue_valid    = v.iv;
    sb_if.issue_rs1      = v.rs1;
    sb_if.issue_use_rs1  = v.u1;
    sb_if.issue_rs2      = v.rs2;
    sb_if.issue_use_rs2  = v.u2;
    sb_if.issue_rd       = v.rd;
    sb_if.issue_wr       = v.wr;
    sb_if.wb_valid       = v.wbv;
    sb_if.wb_rd          = v.wbrd;
    sb_if.flush          = v.fl;
    #2;
    n_vec++;
    check("stall", 32'(sb_if.stall), 32'(v.exp_stall));
    check("issue_fire", 32'(sb_if.issue_fire), 32'(v.exp_fire));
    exp_q.push_back({v.exp_pend, |v.exp_pend, v.exp_err});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: expected queue empty at vector %0d", n_vec);
    end else begin
      exp_r = exp_q.pop_front();
      act_r = {sb_if.pending, sb_if.busy, sb_if.err_underflow};
      check("pending", act_r[33:2], exp_r[33:2]);
      check("busy", 32'(act_r[1]), 32'(exp_r[1]));
      check("err_underflow", 32'(act_r[0]), 32'(exp_r[0]));
    end
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic model_haz(input logic u, input logic [4:0] rs,
                                     input logic wbv, input logic [4:0] wbrd);
    if (!u || rs == 5'd31 || cnt_m[rs] == 0) return 1'b0;
    if (wbv && wbrd == rs && cnt_m[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Build one random vector, fill in expectations from the model, advance the model.
  task automatic random_vec(output vec_t v);
    logic cap;
    logic [31:0] pm;
    v.rst  = ($urandom_range(0, 99) < 2);
    v.fl   = ($urandom_range(0, 99) < 3);
    v.iv   = ($urandom_range(0, 99) < 70);
    v.rs1  = pick_reg();  v.u1 = $urandom_range(0, 1);
    v.rs2  = pick_reg();  v.u2 = $urandom_range(0, 1);
    v.rd   = pick_reg();  v.wr = ($urandom_range(0, 99) < 75);
    v.wbv  = ($urandom_range(0, 99) < 40);
    v.wbrd = pick_reg();
    cap = v.wr && v.rd != 5'd31 && cnt_m[v.rd] == 3 && !(v.wbv && v.wbrd == v.rd);
    v.exp_stall = v.iv && !v.fl &&
                  (model_haz(v.u1, v.rs1, v.wbv, v.wbrd) ||
                   model_haz(v.u2, v.rs2, v.wbv, v.wbrd) || cap);
    v.exp_fire = v.iv && !v.exp_stall && !v.fl;
    if (v.rst) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      err_m = 1'b0;
    end else if (v.fl) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
    end else begin
      if (v.wbv && v.wbrd != 5'd31) begin
        if (cnt_m[v.wbrd] == 0) err_m = 1'b1;
        else cnt_m[v.wbrd] = cnt_m[v.wbrd] - 1;
      end
      if (v.exp_fire && v.wr && v.rd != 5'd31) cnt_m[v.rd] = cnt_m[v.rd] + 1;
    end
    pm = '0;
    foreach (cnt_m[i]) if (cnt_m[i] != 0) pm[i] = 1'b1;
    v.exp_pend = pm;
    v.exp_err  = err_m;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    sb_if.issue_valid = 0; sb_if.issue_rs1 = 0; sb_if.issue_rs2 = 0;
    sb_if.issue_use_rs1 = 0; sb_if.issue_use_rs2 = 0; sb_if.issue_rd = 0;
    sb_if.issue_wr = 0; sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush = 0;

    //      rst iv rs1 u1 rs2 u2 rd wr wbv wbrd fl  stall fire pend          err
    // reset, issue/stall/bypass on r5
    add_vec(1, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0,  0, 0, 32'h0000_0000, 0);
    add_vec(0, 1,  0, 0,  0, 0,  5, 1, 0,  0,  0,  0, 1, 32'h0000_0020, 0);
    add_vec(0, 1,  5, 1,  0, 0,  0, 0, 0,  0,  0,  1, 0, 32'h0000_0020, 0);
    add_vec(0, 1,  5, 1,  0, 0,  0, 0, 1,  5,  0,  0, 1, 32'h0000_0000, 0);
    // capacity on r7
    add_vec(0, 1,  0, 0,  0, 0,  7, 1, 0,  0,  0,  0, 1, 32'h0000_0080, 0);
    add_vec(0, 1,  0, 0,  0, 0,  7, 1, 0,  0,  0,  0, 1, 32'h0000_0080, 0);
    add_vec(0, 1,  0, 0,  0, 0,  7, 1, 0,  0,  0,  0, 1, 32'h0000_0080, 0);
    add_vec(0, 1,  0, 0,  0, 0,  7, 1, 0,  0,  0,  1, 0, 32'h0000_0080, 0);
    add_vec(0, 1,  0, 0,  0, 0,  7, 1, 1,  7,  0,  0, 1, 32'h0000_0080, 0);
    add_vec(0, 1,  7, 1,  0, 0,  0, 0, 1,  7,  0,  1, 0, 32'h0000_0080, 0);
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 1,  7,  0,  0, 0, 32'h0000_0080, 0);
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 1,  7,  0,  0, 0, 32'h0000_0000, 0);
    // zero register is never tracked
    add_vec(0, 1,  0, 0,  0, 0, 31, 1, 0,  0,  0,  0, 1, 32'h0000_0000, 0);
    add_vec(0, 1, 31, 1, 31, 1,  0, 0, 0,  0,  0,  0, 1, 32'h0000_0000, 0);
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 1, 31,  0,  0, 0, 32'h0000_0000, 0);
    // underflow is sticky
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 1,  9,  0,  0, 0, 32'h0000_0000, 1);
    add_vec(0, 1,  0, 0,  0, 0,  3, 1, 0,  0,  0,  0, 1, 32'h0000_0008, 1);
    add_vec(0, 1,  0, 0,  0, 0,  3, 1, 0,  0,  0,  0, 1, 32'h0000_0008, 1);
    add_vec(0, 1,  0, 0,  0, 0,  4, 1, 0,  0,  0,  0, 1, 32'h0000_0018, 1);
    // flush with an issue present
    add_vec(0, 1,  0, 0,  0, 0,  3, 1, 0,  0,  1,  0, 0, 32'h0000_0000, 1);
    add_vec(1, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0,  0, 0, 32'h0000_0000, 0);
    // simultaneous issue/writeback on r2, then reset mid-stall
    add_vec(0, 1,  0, 0,  0, 0,  2, 1, 0,  0,  0,  0, 1, 32'h0000_0004, 0);
    add_vec(0, 1,  0, 0,  0, 0,  2, 1, 1,  2,  0,  0, 1, 32'h0000_0004, 0);
    add_vec(0, 1,  0, 0,  2, 1,  0, 0, 0,  0,  0,  1, 0, 32'h0000_0004, 0);
    add_vec(1, 1,  0, 0,  2, 1,  0, 0, 0,  0,  0,  1, 0, 32'h0000_0000, 0);
    add_vec(0, 1,  0, 0,  2, 1,  0, 0, 0,  0,  0,  0, 1, 32'h0000_0000, 0);
    // use flags, self-dependence, flush discards writeback, flush keeps error
    add_vec(0, 1,  0, 0,  0, 0,  6, 1, 0,  0,  0,  0, 1, 32'h0000_0040, 0);
    add_vec(0, 1,  6, 0,  0, 0,  0, 0, 0,  0,  0,  0, 1, 32'h0000_0040, 0);
    add_vec(0, 1,  6, 1,  0, 0,  6, 1, 0,  0,  0,  1, 0, 32'h0000_0040, 0);
    add_vec(0, 1,  8, 1,  0, 0,  8, 1, 0,  0,  0,  0, 1, 32'h0000_0140, 0);
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 1,  6,  1,  0, 0, 32'h0000_0000, 0);
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 1,  6,  0,  0, 0, 32'h0000_0000, 1);
    add_vec(0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  1,  0, 0, 32'h0000_0000, 1);
    add_vec(0, 1,  0, 0,  0, 0,  1, 1, 0,  0,  0,  0, 1, 32'h0000_0002, 1);
    add_vec(0, 0,  1, 1,  0, 0,  0, 0, 0,  0,  0,  0, 0, 32'h0000_0002, 1);
    add_vec(1, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0,  0, 0, 32'h0000_0000, 0);

    foreach (vecs[i]) run_cycle(vecs[i]);

    // randomized traffic, model starts from the reset just applied
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 1'b0;
    for (int n = 0; n < 600; n++) begin
      random_vec(v);
      run_cycle(v);
    end

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard: %0d expected entries left over", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
